// File: rtl/exmem_reg.sv
// EX/MEM pipeline register: captures EX controls/data, handles stall/flush, owns the LL/SC link bit.
// Optional trap evaluation is enabled by defining EXMEM_TRAP_EN.
module exmem_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        Trap,
   input  logic        TrapCond,
   input  logic        LLSC,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemHalf,
   input  logic        MemByte,
   input  logic        MemSignExtend,
   input  logic        RegWrite,
   input  logic        MemtoReg,
   input  logic        ExcOv,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ReadData2,
   input  logic [4:0]  RegDstOut,
   output logic        M_MemRead,
   output logic        M_MemWrite,
   output logic        M_MemHalf,
   output logic        M_MemByte,
   output logic        M_MemSignExtend,
   output logic        M_RegWrite,
   output logic        M_MemtoReg,
   output logic        M_LLSC,
   output logic [31:0] M_ALUResult,
   output logic [31:0] M_WriteData,
   output logic [4:0]  M_RegDst,
   output logic [31:0] M_SCResult,
   output logic        M_ExcTrap,
   output logic        M_ExcOv,
   output logic        LLbit
);

   logic        mem_read_q,  mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic        mem_half_q,  mem_half_d;
   logic        mem_byte_q,  mem_byte_d;
   logic        mem_sext_q,  mem_sext_d;
   logic        reg_write_q, reg_write_d;
   logic        mem2reg_q,   mem2reg_d;
   logic        llsc_q,      llsc_d;
   logic [31:0] alu_q,       alu_d;
   logic [31:0] wdata_q,     wdata_d;
   logic [4:0]  regdst_q,    regdst_d;
   logic        sc_ok_q,     sc_ok_d;
   logic        exc_trap_q,  exc_trap_d;
   logic        exc_ov_q,    exc_ov_d;
   logic        llbit_q,     llbit_d;

   logic trap_taken;
   logic exc;
   logic is_sc;
   logic is_ll;

`ifdef EXMEM_TRAP_EN
   assign trap_taken = Trap & ((ALUResult != '0) == TrapCond);
`else
   logic unused_trap;
   assign unused_trap = Trap ^ TrapCond;
   assign trap_taken  = 1'b0;
`endif

   assign exc   = trap_taken | ExcOv;
   // SC takes priority when LL and SC decode simultaneously
   assign is_sc = LLSC & MemWrite;
   assign is_ll = LLSC & MemRead & ~MemWrite;

   always_comb begin
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_half_d  = mem_half_q;
      mem_byte_d  = mem_byte_q;
      mem_sext_d  = mem_sext_q;
      reg_write_d = reg_write_q;
      mem2reg_d   = mem2reg_q;
      llsc_d      = llsc_q;
      alu_d       = alu_q;
      wdata_d     = wdata_q;
      regdst_d    = regdst_q;
      sc_ok_d     = sc_ok_q;
      exc_trap_d  = exc_trap_q;
      exc_ov_d    = exc_ov_q;
      llbit_d     = llbit_q;
      if (Flush) begin
         mem_read_d  = 1'b0;
         mem_write_d = 1'b0;
         mem_half_d  = 1'b0;
         mem_byte_d  = 1'b0;
         mem_sext_d  = 1'b0;
         reg_write_d = 1'b0;
         mem2reg_d   = 1'b0;
         llsc_d      = 1'b0;
         alu_d       = '0;
         wdata_d     = '0;
         regdst_d    = '0;
         sc_ok_d     = 1'b0;
         exc_trap_d  = 1'b0;
         exc_ov_d    = 1'b0;
         llbit_d     = 1'b0;
      end else if (!Stall) begin
         mem_read_d  = is_sc ? 1'b0 : MemRead;
         mem_write_d = is_sc ? llbit_q : MemWrite;
         mem_half_d  = MemHalf;
         mem_byte_d  = MemByte;
         mem_sext_d  = MemSignExtend;
         reg_write_d = is_sc ? 1'b1 : RegWrite;
         mem2reg_d   = MemtoReg;
         llsc_d      = LLSC;
         alu_d       = ALUResult;
         wdata_d     = ReadData2;
         regdst_d    = RegDstOut;
         sc_ok_d     = is_sc & llbit_q;
         exc_trap_d  = trap_taken;
         exc_ov_d    = ExcOv;
         if (exc) begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            reg_write_d = 1'b0;
         end else if (is_sc) begin
            llbit_d = 1'b0;
         end else if (is_ll) begin
            llbit_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_half_q  <= 1'b0;
         mem_byte_q  <= 1'b0;
         mem_sext_q  <= 1'b0;
         reg_write_q <= 1'b0;
         mem2reg_q   <= 1'b0;
         llsc_q      <= 1'b0;
         alu_q       <= '0;
         wdata_q     <= '0;
         regdst_q    <= '0;
         sc_ok_q     <= 1'b0;
         exc_trap_q  <= 1'b0;
         exc_ov_q    <= 1'b0;
         llbit_q     <= 1'b0;
      end else begin
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_half_q  <= mem_half_d;
         mem_byte_q  <= mem_byte_d;
         mem_sext_q  <= mem_sext_d;
         reg_write_q <= reg_write_d;
         mem2reg_q   <= mem2reg_d;
         llsc_q      <= llsc_d;
         alu_q       <= alu_d;
         wdata_q     <= wdata_d;
         regdst_q    <= regdst_d;
         sc_ok_q     <= sc_ok_d;
         exc_trap_q  <= exc_trap_d;
         exc_ov_q    <= exc_ov_d;
         llbit_q     <= llbit_d;
      end
   end

   assign M_MemRead       = mem_read_q;
   assign M_MemWrite      = mem_write_q;
   assign M_MemHalf       = mem_half_q;
   assign M_MemByte       = mem_byte_q;
   assign M_MemSignExtend = mem_sext_q;
   assign M_RegWrite      = reg_write_q;
   assign M_MemtoReg      = mem2reg_q;
   assign M_LLSC          = llsc_q;
   assign M_ALUResult     = alu_q;
   assign M_WriteData     = wdata_q;
   assign M_RegDst        = regdst_q;
   assign M_SCResult      = {31'b0, sc_ok_q};
   assign M_ExcTrap       = exc_trap_q;
   assign M_ExcOv         = exc_ov_q;
   assign LLbit           = llbit_q;

endmodule
